riscv_run_ctrl: RTL

RISCV_RUN_CTRL -- requirements
Module: riscv_run_ctrl

---
 rtl/riscv_ctrl_pkg.sv | 8 +
 rtl/riscv_cycle_ctr.sv | 19 +
 rtl/riscv_run_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state encoding and constants for the run controller
package riscv_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DUMP, DONE} run_state_t;
  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam int IMEM_WORDS_DEF = 320;
  localparam int RF_WORDS_DEF = 32;
  localparam int MAX_CYCLES_DEF = 10000;
endpackage

// File: rtl/riscv_cycle_ctr.sv
// riscv_cycle_ctr: run-phase cycle counter with terminal-count flag at MAX_CYCLES-1
module riscv_cycle_ctr import riscv_ctrl_pkg::*; #(
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);
  logic [CW-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= count + CW'(1);
  assign tc = count == LAST;
endmodule

// File: rtl/riscv_run_ctrl.sv
// riscv_run_ctrl: sequences program load, core run and register-file dump
module riscv_run_ctrl import riscv_ctrl_pkg::*; #(
  parameter int IMEM_WORDS = IMEM_WORDS_DEF,
  parameter int RF_WORDS = RF_WORDS_DEF,
  parameter int MAX_CYCLES = MAX_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          ld_valid,
  input  logic [31:0]                   ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  output logic                          imem_we,
  output logic [$clog2(IMEM_WORDS)-1:0] imem_addr,
  output logic [31:0]                   imem_wdata,
  output logic                          core_en,
  input  logic [31:0]                   pc,
  input  logic [31:0]                   inst_out,
  output logic [$clog2(RF_WORDS)-1:0]   rf_rd_addr,
  input  logic [31:0]                   rf_rd_data,
  output logic                          dump_valid,
  output logic [31:0]                   dump_data,
  output logic                          dump_last,
  input  logic                          dump_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          timeout,
  output logic                          load_ovf
);
  localparam int AW = $clog2(IMEM_WORDS);
  localparam int RW = $clog2(RF_WORDS);
  localparam logic [AW:0] LD_MAX = (AW + 1)'(IMEM_WORDS);
  localparam logic [RW-1:0] RF_LAST = RW'(RF_WORDS - 1);
  run_state_t state;
  logic [AW:0] ld_cnt;
  logic [RW-1:0] idx;
  logic go, accept, ebreak, tc, fire, unused;
  assign go = start && (state == IDLE || state == DONE);
  assign ld_ready = state == LOAD;
  assign accept = ld_valid && ld_ready;
  // the load counter saturates at IMEM_WORDS so overflow beats never alias low addresses
  assign imem_we = accept && ld_cnt < LD_MAX;
  assign imem_addr = ld_ready ? ld_cnt[AW-1:0] : '0;
  assign imem_wdata = ld_ready ? ld_data : '0;
  assign core_en = state == RUN;
  assign ebreak = inst_out == EBREAK_INST;
  assign dump_valid = state == DUMP;
  assign rf_rd_addr = dump_valid ? idx : '0;
  assign dump_data = dump_valid ? rf_rd_data : '0;
  assign dump_last = dump_valid && idx == RF_LAST;
  assign fire = dump_valid && dump_ready;
  assign busy = ld_ready || core_en || dump_valid;
  assign done = state == DONE;
  assign unused = ^pc;
  riscv_cycle_ctr #(.MAX_CYCLES(MAX_CYCLES)) u_ctr (
    .clk  (clk),
    .reset(reset),
    .clr  (go),
    .en   (core_en),
    .tc   (tc)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ld_cnt <= '0;
      idx <= '0;
      timeout <= 1'b0;
      load_ovf <= 1'b0;
    end else if (go) begin
      state <= LOAD;
      ld_cnt <= '0;
      timeout <= 1'b0;
      load_ovf <= 1'b0;
    end else if (accept) begin
      if (imem_we) ld_cnt <= ld_cnt + (AW + 1)'(1);
      else load_ovf <= 1'b1;
      if (ld_last) state <= RUN;
    end else if (core_en && (ebreak || tc)) begin
      state <= DUMP;
      timeout <= !ebreak;
      idx <= '0;
    end else if (fire) begin
      idx <= idx + RW'(1);
      if (dump_last) state <= DONE;
    end
endmodule
